// File: rtl/fp32_pkg.sv
// Shared single-precision definitions for the integer converter and the add/sub datapath.
package fp32_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_MANT_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  function automatic logic [31:0] fp32_pack(
    input logic                   sign,
    input logic [FP32_EXP_W-1:0]  exp,
    input logic [FP32_MANT_W-1:0] mant
  );
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/fp32_round.sv
// Rounds a normalised 32-bit magnitude (bit 31 set) to a 23-bit fraction plus exponent.
module fp32_round
  import fp32_pkg::*;
(
  input  logic [31:0]              mag_i,
  input  logic [FP32_EXP_W-1:0]    exp_i,
  input  logic                     mode_i,
  output logic [FP32_MANT_W-1:0]   mant_o,
  output logic [FP32_EXP_W-1:0]    exp_o,
  output logic                     inexact_o
);

  logic [FP32_MANT_W-1:0] mant_s;
  logic                   guard_s;
  logic                   sticky_s;
  logic                   inc_s;
  logic [FP32_MANT_W:0]   sum_s;

  assign mant_s   = mag_i[30:8];
  assign guard_s  = mag_i[7];
  assign sticky_s = |mag_i[6:0];
  // mode 0 is round-to-nearest-even, mode 1 truncates
  assign inc_s    = !mode_i && guard_s && (sticky_s || mant_s[0]);
  assign sum_s    = {1'b0, mant_s} + {{FP32_MANT_W{1'b0}}, inc_s};

  // Fraction overflow renormalises to 1.0 at the next binade.
  always_comb begin
    mant_o    = sum_s[FP32_MANT_W-1:0];
    exp_o     = exp_i;
    inexact_o = guard_s | sticky_s;
    if (sum_s[FP32_MANT_W]) begin
      mant_o = {FP32_MANT_W{1'b0}};
      exp_o  = exp_i + 8'd1;
    end else begin
      mant_o = sum_s[FP32_MANT_W-1:0];
      exp_o  = exp_i;
    end
  end

endmodule

// File: rtl/int_to_fp32.sv
// Iterative 32-bit integer to IEEE754 single converter: one normalising shift per cycle, one rounding step.
module int_to_fp32
  import fp32_pkg::*;
#(
  parameter int BIAS       = FP32_BIAS,
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  localparam logic [FP32_EXP_W-1:0] EXP_INIT = FP32_EXP_W'(BIAS + 31);
  localparam logic                  MODE     = 1'(ROUND_MODE);

  conv_state_t            state_q, state_d;
  logic [31:0]            mag_q, mag_d;
  logic [FP32_EXP_W-1:0]  exp_q, exp_d;
  logic                   sign_q, sign_d;
  logic [31:0]            out_data_q, out_data_d;
  logic                   out_inexact_q, out_inexact_d;
  logic                   out_valid_q, out_valid_d;

  logic                   in_sign_s;
  logic [31:0]            in_mag_s;
  logic [FP32_MANT_W-1:0] rnd_mant_s;
  logic [FP32_EXP_W-1:0]  rnd_exp_s;
  logic                   rnd_inexact_s;

  assign in_sign_s = in_signed & in_data[31];
  assign in_mag_s  = in_sign_s ? (~in_data + 32'd1) : in_data;

  fp32_round u_round (
    .mag_i     (mag_q),
    .exp_i     (exp_q),
    .mode_i    (MODE),
    .mant_o    (rnd_mant_s),
    .exp_o     (rnd_exp_s),
    .inexact_o (rnd_inexact_s)
  );

  // Next-state and datapath updates for the conversion FSM.
  always_comb begin
    state_d       = state_q;
    mag_d         = mag_q;
    exp_d         = exp_q;
    sign_d        = sign_q;
    out_data_d    = out_data_q;
    out_inexact_d = out_inexact_q;
    out_valid_d   = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign_s;
          mag_d   = in_mag_s;
          exp_d   = EXP_INIT;
          // A zero operand skips normalisation and is packed as +0 in ROUND.
          state_d = (in_mag_s == 32'd0) ? ST_ROUND : ST_NORM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_NORM: begin
        if (mag_q[31]) begin
          state_d = ST_ROUND;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      ST_ROUND: begin
        if (mag_q == 32'd0) begin
          out_data_d    = 32'd0;
          out_inexact_d = 1'b0;
        end else begin
          out_data_d    = fp32_pack(sign_q, rnd_exp_s, rnd_mant_s);
          out_inexact_d = rnd_inexact_s;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mag_q         <= 32'd0;
      exp_q         <= {FP32_EXP_W{1'b0}};
      sign_q        <= 1'b0;
      out_data_q    <= 32'd0;
      out_inexact_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      exp_q         <= exp_d;
      sign_q        <= sign_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule
